rd_req_arbiter: RTL and testbench

Round-robin arbiter that shares the single command port and data-return path of the read buffer between NUM_REQ user read requesters. It grants one request at a time into the read buffer's command interface, records the granted requester ID in an in-order tag FIFO, and steers the returned user-width read data to the owning requester. It sits between the user read controllers and the read buffer, entirely in the user clock domain.

---
 rtl/rd_req_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_rd_req_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_req_arbiter.sv
// Round-robin read-command arbiter for the read buffer.
// Grants one requester at a time onto the single command port, remembers the
// granted requester in an in-order tag FIFO, and steers returned data beats
// back to the requester at the FIFO head.
module rd_req_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned USER_DATA_WIDTH = 64,
    parameter int unsigned TAG_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_len,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          rd_req_en,
    output logic [AXI_ADDR_WIDTH-1:0]     rd_addr_in,
    output logic [7:0]                    rd_burst_length,
    input  logic                          rd_buffer_cmd_ready,
    input  logic                          user_rd_valid,
    input  logic [USER_DATA_WIDTH-1:0]    user_rd_data,
    input  logic                          user_rd_last,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [USER_DATA_WIDTH-1:0]    rsp_data,
    output logic [NUM_REQ-1:0]            rsp_last,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          orphan_err
);

    localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PtrW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    state_e                    state_q, state_d;
    logic [IdW-1:0]            winner_q, winner_d;
    logic [IdW-1:0]            last_grant_q, last_grant_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;

    logic                      grant_found;
    logic [IdW-1:0]            grant_id;
    logic [IdW-1:0]            cand_id;

    logic [IdW-1:0]            tag_mem [TAG_DEPTH];
    logic [PtrW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]           count_q, count_d;
    logic                      push, pop, fifo_empty, fifo_full;
    logic [IdW-1:0]            head_id;

    logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]         rsp_last_q, rsp_last_d;
    logic [USER_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                       orphan_q, orphan_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(TAG_DEPTH));
    assign head_id    = tag_mem[rd_ptr_q];
    assign pop        = user_rd_valid && user_rd_last && !fifo_empty;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand_id = IdW'((32'(last_grant_q) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    // Command FSM next-state and strobe/ack outputs.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        rd_req_en    = 1'b0;
        req_ack      = '0;
        push         = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_found && rd_buffer_cmd_ready && !fifo_full) begin
                    winner_d = grant_id;
                    addr_d   = req_addr[grant_id*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    len_d    = req_len[grant_id*8 +: 8];
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                rd_req_en = 1'b1;
                if (rd_buffer_cmd_ready) begin
                    req_ack[winner_q] = 1'b1;
                    push              = 1'b1;
                    last_grant_d      = winner_q;
                    state_d           = StGap;
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM and latched command registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            winner_q     <= '0;
            last_grant_q <= IdW'(NUM_REQ - 1);
            addr_q       <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
        end
    end

    // Tag storage; contents need no reset since occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= winner_q;
        end
    end

    // Tag FIFO occupancy next state.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Steer a return beat to the head-of-FIFO owner, or flag it as orphaned.
    always_comb begin
        rsp_valid_d = '0;
        rsp_last_d  = '0;
        rsp_data_d  = '0;
        orphan_d    = 1'b0;
        if (user_rd_valid) begin
            if (fifo_empty) begin
                orphan_d = 1'b1;
            end else begin
                rsp_valid_d[head_id] = 1'b1;
                rsp_last_d[head_id]  = user_rd_last;
                rsp_data_d           = user_rd_data;
            end
        end
    end

    // Registered return outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= '0;
            rsp_last_q  <= '0;
            rsp_data_q  <= '0;
            orphan_q    <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
            orphan_q    <= orphan_d;
        end
    end

    assign rd_addr_in      = addr_q;
    assign rd_burst_length = len_q;
    assign outstanding     = count_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_last        = rsp_last_q;
    assign rsp_data        = rsp_data_q;
    assign orphan_err      = orphan_q;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Bench for rd_req_arbiter: table of arbitration vectors plus hand sequences
// for stalls, FIFO-full, push/pop overlap, orphans and mid-burst reset.
module tb_rd_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TD = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*8-1:0] req_len;
    logic [NR-1:0]   req_ack;
    logic            rd_req_en;
    logic [AW-1:0]   rd_addr_in;
    logic [7:0]      rd_burst_length;
    logic            rd_buffer_cmd_ready;
    logic            user_rd_valid;
    logic [DW-1:0]   user_rd_data;
    logic            user_rd_last;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [NR-1:0]   rsp_last;
    logic [$clog2(TD):0] outstanding;
    logic            orphan_err;

    rd_req_arbiter #(
        .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .USER_DATA_WIDTH(DW), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_len(req_len), .req_ack(req_ack), .rd_req_en(rd_req_en),
        .rd_addr_in(rd_addr_in), .rd_burst_length(rd_burst_length),
        .rd_buffer_cmd_ready(rd_buffer_cmd_ready), .user_rd_valid(user_rd_valid),
        .user_rd_data(user_rd_data), .user_rd_last(user_rd_last),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] mask;
        logic [31:0]   base;
        logic [7:0]    len;
        int            win;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [7:0]  len;
    } cmd_t;

    typedef struct {
        int          id;
        logic [63:0] data;
        logic        last;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   tag_model[$];
    vec_t tbl[9];

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic [63:0] seed = 64'h1000;

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reqs(input logic [31:0] base, input logic [7:0] len);
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = base + 32'(i) * 32'h100;
            req_len[i*8 +: 8]    = len + 8'(i);
        end
    endtask

    task automatic wait_cmd_done();
        for (int i = 0; i < 60 && cmd_q.size() != 0; i++) step();
        if (cmd_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: pending %0d want 0", cmd_q.size());
            cmd_q.delete();
        end
        req_valid = '0;
    endtask

    task automatic expect_cmd(input logic [31:0] base, input logic [7:0] len,
                              input int win);
        cmd_t c;
        c.id   = win;
        c.addr = base + 32'(win) * 32'h100;
        c.len  = len + 8'(win);
        cmd_q.push_back(c);
        tag_model.push_back(win);
    endtask

    task automatic issue(input logic [NR-1:0] mask, input logic [31:0] base,
                         input logic [7:0] len, input int win);
        set_reqs(base, len);
        expect_cmd(base, len, win);
        req_valid = mask;
        wait_cmd_done();
    endtask

    // Drive a return of nbeats for the oldest outstanding command; caller is at posedge+1.
    task automatic drive_ret(input int nbeats);
        rsp_t r;
        if (tag_model.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL model_empty: got 0 tags want >0");
            return;
        end
        for (int b = 0; b < nbeats; b++) begin
            seed          = seed + 64'h11;
            user_rd_valid = 1'b1;
            user_rd_data  = seed;
            user_rd_last  = (b == nbeats - 1);
            r.id   = tag_model[0];
            r.data = seed;
            r.last = user_rd_last;
            rsp_q.push_back(r);
            step();
        end
        user_rd_valid = 1'b0;
        user_rd_last  = 1'b0;
        void'(tag_model.pop_front());
    endtask

    task automatic monitor();
        cmd_t c;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rd_req_en && rd_buffer_cmd_ready) begin
                    if (cmd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd: got addr %0h want none", rd_addr_in);
                    end else begin
                        c = cmd_q.pop_front();
                        chk("req_ack", 64'(req_ack), 64'(1) << c.id);
                        chk("rd_addr_in", 64'(rd_addr_in), 64'(c.addr));
                        chk("rd_burst_length", 64'(rd_burst_length), 64'(c.len));
                    end
                end else begin
                    chk("req_ack_idle", 64'(req_ack), 64'h0);
                end
                if (|rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid %0h want 0", rsp_valid);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rsp_valid", 64'(rsp_valid), 64'(1) << r.id);
                        chk("rsp_last", 64'(rsp_last), r.last ? (64'(1) << r.id) : 64'h0);
                        chk("rsp_data", rsp_data, r.data);
                    end
                end else begin
                    chk("rsp_last_idle", 64'(rsp_last), 64'h0);
                    chk("rsp_data_idle", rsp_data, 64'h0);
                end
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_req_en"}, 64'(rd_req_en), 64'h0);
        chk({tag, "_rd_addr_in"}, 64'(rd_addr_in), 64'h0);
        chk({tag, "_rd_burst_length"}, 64'(rd_burst_length), 64'h0);
        chk({tag, "_req_ack"}, 64'(req_ack), 64'h0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
        chk({tag, "_rsp_last"}, 64'(rsp_last), 64'h0);
        chk({tag, "_rsp_data"}, rsp_data, 64'h0);
        chk({tag, "_outstanding"}, 64'(outstanding), 64'h0);
        chk({tag, "_orphan_err"}, 64'(orphan_err), 64'h0);
    endtask

    initial begin
        int seen;

        // Winners follow from the rotating pointer, which starts at requester 0.
        tbl[0] = '{4'b0100, 32'h0000_0E00, 8'd6, 2};
        tbl[1] = '{4'b1111, 32'h0000_2000, 8'd1, 3};
        tbl[2] = '{4'b1111, 32'h0000_2800, 8'd2, 0};
        tbl[3] = '{4'b1010, 32'h0000_3000, 8'd3, 1};
        tbl[4] = '{4'b1010, 32'h0000_3800, 8'd4, 3};
        tbl[5] = '{4'b0011, 32'h0000_4000, 8'd5, 0};
        tbl[6] = '{4'b0001, 32'h0000_4800, 8'd6, 0};
        tbl[7] = '{4'b0110, 32'h0000_5000, 8'd7, 1};
        tbl[8] = '{4'b1001, 32'h0000_5800, 8'd8, 3};

        fork
            monitor();
            begin
                #1ms;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1, "watchdog");
            end
        join_none

        reset_n             = 1'b0;
        req_valid           = '0;
        req_addr            = '0;
        req_len             = '0;
        rd_buffer_cmd_ready = 1'b1;
        user_rd_valid       = 1'b0;
        user_rd_data        = '0;
        user_rd_last        = 1'b0;
        repeat (3) step();
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        step();

        foreach (tbl[k]) issue(tbl[k].mask, tbl[k].base, tbl[k].len, tbl[k].win);
        chk("outstanding_after_table", 64'(outstanding), 64'd9);

        // Command port stalls for five cycles while the command is presented.
        set_reqs(32'h0000_6000, 8'd3);
        expect_cmd(32'h0000_6000, 8'd3, 1);
        req_valid = 4'b0010;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            step();
            if (rd_req_en) seen = 1;
        end
        chk("stall_strobe_seen", 64'(seen), 64'd1);
        rd_buffer_cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rd_req_en", 64'(rd_req_en), 64'd1);
            chk("stall_rd_addr_in", 64'(rd_addr_in), 64'h6100);
            chk("stall_req_ack", 64'(req_ack), 64'h0);
            step();
        end
        rd_buffer_cmd_ready = 1'b1;
        wait_cmd_done();
        chk("outstanding_after_stall", 64'(outstanding), 64'd10);

        // Fill the tag FIFO with all requesters continuously valid.
        for (int j = 0; j < 6; j++) begin
            issue(4'b1111, 32'h0001_0000 + 32'(j) * 32'h1000, 8'd2, (2 + j) % 4);
        end
        chk("outstanding_full", 64'(outstanding), 64'd16);

        // A full FIFO must hold off the next grant.
        set_reqs(32'h000A_0000, 8'd1);
        expect_cmd(32'h000A_0000, 8'd1, 0);
        req_valid = 4'b0001;
        seen = 0;
        repeat (10) begin
            step();
            if (rd_req_en) seen = 1;
        end
        chk("full_blocks_grant", 64'(seen), 64'd0);
        drive_ret(2);
        chk("outstanding_after_one_pop", 64'(outstanding), 64'd15);
        wait_cmd_done();
        chk("outstanding_refilled", 64'(outstanding), 64'd16);

        for (int j = 0; j < 8; j++) drive_ret(1 + j % 3);
        chk("outstanding_half", 64'(outstanding), 64'd8);

        // Last beat of the head command lands on the same edge as a new acceptance.
        set_reqs(32'h000B_0000, 8'd5);
        expect_cmd(32'h000B_0000, 8'd5, 3);
        req_valid = 4'b1000;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            step();
            if (rd_req_en) seen = 1;
        end
        chk("overlap_strobe_seen", 64'(seen), 64'd1);
        drive_ret(1);
        req_valid = '0;
        chk("outstanding_overlap", 64'(outstanding), 64'd8);
        wait_cmd_done();

        while (tag_model.size() > 0) drive_ret(2);
        chk("outstanding_drained", 64'(outstanding), 64'd0);

        // Return beat with nothing outstanding.
        step();
        user_rd_valid = 1'b1;
        user_rd_data  = 64'hDEAD;
        user_rd_last  = 1'b1;
        step();
        user_rd_valid = 1'b0;
        user_rd_last  = 1'b0;
        chk("orphan_pulse", 64'(orphan_err), 64'd1);
        chk("orphan_no_rsp", 64'(rsp_valid), 64'h0);
        step();
        chk("orphan_single_cycle", 64'(orphan_err), 64'd0);

        // Reset in the middle of a burst discards the in-flight tag.
        issue(4'b0001, 32'h000C_0000, 8'd4, 0);
        chk("outstanding_before_reset", 64'(outstanding), 64'd1);
        begin
            rsp_t r;
            r.id          = 0;
            r.data        = 64'hBEEF;
            r.last        = 1'b0;
            user_rd_valid = 1'b1;
            user_rd_data  = 64'hBEEF;
            user_rd_last  = 1'b0;
            rsp_q.push_back(r);
        end
        step();
        user_rd_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        cmd_q.delete();
        rsp_q.delete();
        tag_model.delete();
        #1;
        chk_reset_outputs("midrst");
        step();
        step();
        reset_n = 1'b1;
        step();
        user_rd_valid = 1'b1;
        user_rd_data  = 64'hCAFE;
        user_rd_last  = 1'b1;
        step();
        user_rd_valid = 1'b0;
        user_rd_last  = 1'b0;
        chk("post_reset_orphan", 64'(orphan_err), 64'd1);
        chk("post_reset_no_rsp", 64'(rsp_valid), 64'h0);
        step();
        step();

        chk("cmd_queue_left", 64'(cmd_q.size()), 64'd0);
        chk("rsp_queue_left", 64'(rsp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
